// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Round-robin arbiter and sequencer for the single shared memory port.
//   Grants one of up to NREQ requesters at a time. It drives the select of the
//   address/wdata/we steering muxes and runs the issue/wait/acknowledge
//   handshake with a variable-latency memory.
//
//   Sequence: IDLE -> ISSUE -> WAIT -> DONE -> IDLE. ISSUE goes straight to DONE
//   when mem_ready arrives in that cycle.
//
// Optional feature: define MEM_ARB_TIMEOUT_EN to build the WAIT timeout. After
//   TIMEOUT WAIT cycles without mem_ready the access is forced to DONE, and err
//   pulses together with ack. When the macro is undefined, WAIT has no limit
//   and err is tied low.
//
// Ports
//   clk        in   1     rising-edge clock
//   rst_n      in   1     asynchronous active-low reset
//   req        in   NREQ  per-requester request, held until its ack
//   we_in      in   NREQ  per-requester write flag, valid while req is high
//   mem_ready  in   1     memory access complete (1-cycle pulse)
//   mem_sel    out  SELW  granted index, drives the mux4 selects
//   mem_en     out  1     memory strobe, 1 cycle per transaction
//   mem_we     out  1     write strobe, qualified by mem_en
//   ack        out  NREQ  one-hot completion pulse to the granted requester
//   busy       out  1     high whenever the sequencer is not idle
//   err        out  1     timeout abort pulse, coincident with ack
module mem_port_arbiter #(
    parameter int NREQ    = 4,
    parameter int SELW    = 2,
    parameter int TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] we_in,
    input  logic            mem_ready,
    output logic [SELW-1:0] mem_sel,
    output logic            mem_en,
    output logic            mem_we,
    output logic [NREQ-1:0] ack,
    output logic            busy,
    output logic            err
);

    if (NREQ < 2 || NREQ > 4 || TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_param
        $error("mem_port_arbiter: illegal NREQ or TIMEOUT");
    end

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t          r_state, w_state_n;
    logic [SELW-1:0] r_ptr, w_ptr_n;
    logic [SELW-1:0] r_sel, w_sel_n;
    logic [SELW-1:0] w_grant, w_idx;
    logic            w_found;
    logic            r_en, w_en_n;
    logic            r_we, w_we_n;
    logic [NREQ-1:0] r_ack, w_ack_n;
    logic [NREQ-1:0] w_onehot;
`ifdef MEM_ARB_TIMEOUT_EN
    logic [7:0]      r_cnt, w_cnt_n;
    logic            r_err, w_err_n;
`endif

    // Rotating priority search. It starts at r_ptr, so the requester served
    // last is tried last.
    always_comb begin
        w_found = 1'b0;
        w_grant = r_ptr;
        w_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = SELW'((int'(r_ptr) + k) % NREQ);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_grant = w_idx;
            end
        end
    end

    assign w_onehot = NREQ'(1) << r_sel;

    // NOTE: every signal gets a default before the case statement. That way no
    // path leaves a signal unassigned, which would infer a latch.
    always_comb begin
        w_state_n = r_state;
        w_ptr_n   = r_ptr;
        w_sel_n   = r_sel;
        w_we_n    = r_we;
        w_en_n    = 1'b0;
        w_ack_n   = '0;
`ifdef MEM_ARB_TIMEOUT_EN
        w_cnt_n   = r_cnt;
        w_err_n   = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                // mem_sel keeps the last grant while idle so the muxes stay stable.
                if (w_found) begin
                    w_state_n = S_ISSUE;
                    w_sel_n   = w_grant;
                    w_we_n    = we_in[w_grant];
                    w_en_n    = 1'b1;
                end
            end
            S_ISSUE: begin
                if (mem_ready) begin
                    w_state_n = S_DONE;
                    w_ack_n   = w_onehot;
                end else begin
                    w_state_n = S_WAIT;
`ifdef MEM_ARB_TIMEOUT_EN
                    w_cnt_n   = 8'd0;
`endif
                end
            end
            S_WAIT: begin
                if (mem_ready) begin
                    w_state_n = S_DONE;
                    w_ack_n   = w_onehot;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (r_cnt == 8'(TIMEOUT - 1)) begin
                    w_state_n = S_DONE;
                    w_ack_n   = w_onehot;
                    w_err_n   = 1'b1;
                end else begin
                    w_cnt_n   = r_cnt + 8'd1;
                end
`endif
            end
            S_DONE: begin
                // ack is high during this cycle. Lower the served requester's priority.
                w_state_n = S_IDLE;
                w_ptr_n   = (int'(r_sel) == NREQ - 1) ? '0 : r_sel + SELW'(1);
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_sel   <= '0;
            r_en    <= 1'b0;
            r_we    <= 1'b0;
            r_ack   <= '0;
        end else begin
            r_state <= w_state_n;
            r_ptr   <= w_ptr_n;
            r_sel   <= w_sel_n;
            r_en    <= w_en_n;
            r_we    <= w_we_n;
            r_ack   <= w_ack_n;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 8'd0;
            r_err <= 1'b0;
        end else begin
            r_cnt <= w_cnt_n;
            r_err <= w_err_n;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign mem_sel = r_sel;
    assign mem_en  = r_en;
    assign mem_we  = r_we;
    assign ack     = r_ack;
    assign busy    = (r_state != S_IDLE);

endmodule
